apb_rst_seq: RTL and testbench
==============================

# apb_rst_seq

Reset sequencer that consumes the software reset request from the PMU (`sys_rst_n`) and a watchdog reset request, and drives `NUM_DOM` domain resets. All domain resets assert together; they release one at a time in ascending index order. It sits between the PMU and the SoC reset tree. An APB slave reports sequencer state, reset cause and reset count.

## Interface
- `ADDR_WIDTH`, default 32: APB address width.
- `DATA_WIDTH`, default 32: APB data width.
- `NUM_DOM`, default 4: number of reset domains, 1..8.
- `HOLD_CYCLES`, default 16: minimum request-free cycles that all domains are held in reset, ≥1.
- `STEP_CYCLES`, default 8: cycles between successive domain releases, ≥1.

Ports:
- `pclk`  in  1: clock.
- `presetn`  in  1: reset, asynchronous, active-low.
- `psel`, `penable`, `pwrite`  in  1: APB control.
- `paddr`  in  ADDR_WIDTH: APB address; only `[7:0]` decoded.
- `pwdata`  in  DATA_WIDTH: APB write data.
- `prdata`  out  DATA_WIDTH: APB read data, registered.
- `sys_rst_n`  in  1: PMU software reset control. A 1→0 transition is a software request.
- `wdt_rst_req`  in  1: watchdog request, level, synchronous to `pclk`.
- `dom_rst_n`  out  NUM_DOM: domain resets, active-low, registered.
- `seq_busy`  out  1: high whenever state ≠ RUN, registered.

## Operation
**APB access**
- Write strobe: `psel & penable & pwrite`.
- Read: on `psel & !penable & !pwrite`, `prdata` loads the addressed register. Unmapped addresses read 0.
- Writes to read-only fields and to unmapped addresses are ignored.

**Registers**
- 0x00 STATUS (RO):
  - [1:0] state: HOLD=0, RELEASE=1, RUN=2.
  - [2] busy.
  - [5:4] last cause: POR=0, SW=1, WDT=2, SW+WDT same cycle=3.
  - [8+NUM_DOM-1:8] current `dom_rst_n`.
- 0x04 RST_CNT: [15:0] count of accepted requests, saturating at 0xFFFF. Any write clears it to 0.
- 0x08 CTRL: [0] `wdt_en`, reset 1. When 0, `wdt_rst_req` is ignored.

**Request detection**
- `sys_rst_n` is registered into `sys_q`; `sys_q` resets to 0.
- `sw_req = sys_q & !sys_rst_n`. A PMU register that resets to 0 therefore never triggers a request.
- `wd_req = wdt_rst_req & wdt_en`.
- `req = sw_req | wd_req`.

**FSM**
- Reset state HOLD. A power-on sequence runs automatically after `presetn` release.
- HOLD:
  - All `dom_rst_n` = 0.
  - Counter `cnt` increments each cycle with `!req` and clears on `req`.
  - When `cnt==HOLD_CYCLES-1 & !req`: go to RELEASE, `cnt<=0`, `idx<=0`.
- RELEASE:
  - `cnt` increments each cycle.
  - When `cnt==STEP_CYCLES-1`: `dom_rst_n[idx]<=1`, `cnt<=0`, `idx<=idx+1`.
  - When the released index is `NUM_DOM-1`: go to RUN.
- RUN: all `dom_rst_n` = 1.
- `req` in RELEASE or RUN:
  - Go to HOLD at the same edge.
  - All `dom_rst_n<=0`, `cnt<=0`.
  - Cause is recorded and RST_CNT increments.
  - `req` has priority over a release scheduled at that edge.
- `req` in HOLD: restarts the hold count and updates the cause. RST_CNT is not incremented.
- RST_CNT clear write and increment in the same cycle: clear wins, result 0.

## Timing
**Reset values**
- `dom_rst_n`=0, `seq_busy`=1, `prdata`=0.
- State HOLD, `cnt`=0, `idx`=0, cause POR, RST_CNT=0, `wdt_en`=1.

**Release timing** (edges numbered from the first rising edge after `presetn` deasserts, with no requests)
- Leave HOLD at edge `HOLD_CYCLES`.
- `dom_rst_n[i]` rises at edge `HOLD_CYCLES + (i+1)*STEP_CYCLES`.
- `seq_busy` falls at the same edge as the last domain release.

**Assertion latency**
- `req` true before edge k → all `dom_rst_n` low after edge k, a single-cycle latency.
- `sys_rst_n` falling before edge k is detected at edge k.

**Other**
- `prdata` is valid in the APB access phase following the setup phase.
- Asynchronous `presetn` mid-sequence forces all reset values immediately, and the power-on sequence restarts.

## Test plan
- **POR sequence**, defaults: `dom_rst_n` = 0000 until edge 23; 0001 at 24, 0011 at 32, 0111 at 40, 1111 at 48. `seq_busy` falls at 48. STATUS reads 0x0F02.
- **Software reset**: in RUN, write PMU 1 then 0 → `dom_rst_n`=0 one edge after the 1→0 transition, cause=1, RST_CNT=1. The full release sequence repeats 16+32 edges later.
- **Watchdog**:
  - Pulse `wdt_rst_req` at edge 36 (mid-RELEASE) → all domains low, cause=2.
  - Held high for 10 cycles → first release 16+8 edges after it drops.
- **Watchdog masked / simultaneous**:
  - Write CTRL=0, pulse watchdog → no reset, RST_CNT unchanged.
  - Re-enable; SW and WDT requests in the same cycle → cause=3, RST_CNT +1.
- **Counter rules**:
  - Write 0x04 in the same cycle as a request → RST_CNT=0.
  - Force 0xFFFF, then another request → stays 0xFFFF.
  - Read 0x0C → 0.
- **Async reset mid-RELEASE**: assert `presetn` at edge 30 → `dom_rst_n`=0 immediately, cause=POR, RST_CNT=0. The POR timing repeats.

Source files
------------

// File: rtl/apb_rst_seq.sv
// Reset sequencer: asserts all domain resets together on a power-on, software
// or watchdog request, then releases them one at a time in index order.
module apb_rst_seq #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_DOM     = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 8
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  input  logic                  sys_rst_n,
  input  logic                  wdt_rst_req,
  output logic [NUM_DOM-1:0]    dom_rst_n,
  output logic                  seq_busy
);

  localparam int CNT_MAX = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

  localparam logic [7:0] ADDR_STATUS  = 8'h00;
  localparam logic [7:0] ADDR_RST_CNT = 8'h04;
  localparam logic [7:0] ADDR_CTRL    = 8'h08;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_SW   = 2'd1,
    CAUSE_WDT  = 2'd2,
    CAUSE_BOTH = 2'd3
  } cause_e;

  state_e                  state_q, state_d;
  cause_e                  cause_q, cause_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_DOM-1:0]      dom_q, dom_d;
  logic [15:0]             rst_cnt_q, rst_cnt_d;
  logic [DATA_WIDTH-1:0]   prdata_q, rd_data;
  logic                    busy_q;
  logic                    sys_q;
  logic                    wdt_en_q;
  logic                    cnt_inc;

  logic       sw_req, wd_req, req;
  cause_e     req_cause;
  logic       wr_en, rd_en;
  logic [7:0] addr;
  logic       unused_ok;

  assign unused_ok = ^{paddr[ADDR_WIDTH-1:8], pwdata[DATA_WIDTH-1:1]};

  // A PMU register that resets to 0 never looks like a falling edge.
  assign sw_req    = sys_q & ~sys_rst_n;
  assign wd_req    = wdt_rst_req & wdt_en_q;
  assign req       = sw_req | wd_req;
  assign req_cause = cause_e'({wd_req, sw_req});

  assign wr_en = psel & penable & pwrite;
  assign rd_en = psel & ~penable & ~pwrite;
  assign addr  = paddr[7:0];

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    cnt_inc = 1'b0;
    unique case (state_q)
      ST_HOLD: begin
        dom_d = '0;
        if (req) begin
          cnt_d   = '0;
          cause_d = req_cause;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE, ST_RUN: begin
        if (req) begin
          // A request beats any release scheduled for the same edge.
          state_d = ST_HOLD;
          dom_d   = '0;
          cnt_d   = '0;
          cause_d = req_cause;
          cnt_inc = 1'b1;
        end else if (state_q == ST_RUN) begin
          dom_d = '1;
        end else if (cnt_q == STEP_LAST) begin
          dom_d[idx_q] = 1'b1;
          cnt_d        = '0;
          idx_d        = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  // Clearing write wins over a simultaneous increment.
  always_comb begin
    rst_cnt_d = rst_cnt_q;
    if (wr_en && addr == ADDR_RST_CNT) rst_cnt_d = '0;
    else if (cnt_inc && rst_cnt_q != 16'hFFFF) rst_cnt_d = rst_cnt_q + 16'd1;
  end

  always_comb begin
    rd_data = '0;
    unique case (addr)
      ADDR_STATUS: begin
        rd_data[1:0]          = state_q;
        rd_data[2]            = busy_q;
        rd_data[5:4]          = cause_q;
        rd_data[8 +: NUM_DOM] = dom_q;
      end
      ADDR_RST_CNT: rd_data[15:0] = rst_cnt_q;
      ADDR_CTRL:    rd_data[0]    = wdt_en_q;
      default:      rd_data       = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= ST_HOLD;
      cause_q   <= CAUSE_POR;
      cnt_q     <= '0;
      idx_q     <= '0;
      dom_q     <= '0;
      busy_q    <= 1'b1;
      sys_q     <= 1'b0;
      wdt_en_q  <= 1'b1;
      rst_cnt_q <= '0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      dom_q     <= dom_d;
      busy_q    <= (state_d != ST_RUN);
      sys_q     <= sys_rst_n;
      rst_cnt_q <= rst_cnt_d;
      if (wr_en && addr == ADDR_CTRL) wdt_en_q <= pwdata[0];
      if (rd_en) prdata_q <= rd_data;
    end
  end

  assign prdata    = prdata_q;
  assign dom_rst_n = dom_q;
  assign seq_busy  = busy_q;

endmodule

// File: tb/tb_apb_rst_seq.sv
// Scoreboard bench for apb_rst_seq: expected domain-reset vectors are queued
// with the edge they must appear at; APB read data is queued per access.
module tb_apb_rst_seq;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int ND = 4;
  localparam int HC = 16;
  localparam int SC = 8;

  typedef struct {
    int          at;
    logic [31:0] val;
    string       tag;
  } exp_t;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          sys_rst_n;
  logic          wdt_rst_req;
  logic [ND-1:0] dom_rst_n;
  logic          seq_busy;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc;
  exp_t dom_q[$];
  exp_t rd_q[$];

  apb_rst_seq #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_DOM(ND),
    .HOLD_CYCLES(HC), .STEP_CYCLES(SC)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .sys_rst_n(sys_rst_n), .wdt_rst_req(wdt_rst_req),
    .dom_rst_n(dom_rst_n), .seq_busy(seq_busy)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got cyc=%0d required finish", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Edge counter: edge 1 is the first rising edge after presetn releases.
  always @(posedge pclk or negedge presetn) begin
    if (!presetn) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(negedge pclk) begin : mon
    exp_t e;
    while (dom_q.size() > 0 && dom_q[0].at <= cyc) begin
      e = dom_q.pop_front();
      if (e.at != cyc) check({e.tag, "_late"}, cyc, e.at);
      else             check(e.tag, {27'd0, seq_busy, dom_rst_n}, e.val);
    end
  end

  task automatic push_dom(input int at, input logic busy, input logic [ND-1:0] dom, input string tag);
    exp_t e;
    e.at  = at;
    e.val = {27'd0, busy, dom};
    e.tag = tag;
    dom_q.push_back(e);
  endtask

  // Full release sequence for a hold that restarted at edge b (b=0 for POR).
  task automatic push_seq(input int b);
    push_dom((b == 0) ? 1 : b, 1'b1, '0, "dom_assert");
    for (int i = 0; i < ND; i++) begin
      push_dom(b + HC + SC*(i+1) - 1, 1'b1, ND'((1 << i) - 1), "dom_pre_rel");
      push_dom(b + HC + SC*(i+1), (i != ND-1), ND'((1 << (i+1)) - 1), "dom_rel");
    end
  endtask

  task automatic step();
    @(negedge pclk);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) step();
  endtask

  task automatic apb_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
    exp_t e;
    e.at = 0; e.val = exp; e.tag = tag;
    rd_q.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = AW'(a);
    step();
    penable = 1'b1;
    e = rd_q.pop_front();
    check(e.tag, prdata, e.val);
    step();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = AW'(a); pwdata = d;
    step();
    penable = 1'b1;
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Drop sys_rst_n for one cycle; the request lands on the next edge (b).
  task automatic sw_pulse(output int b);
    sys_rst_n = 1'b0;
    b = cyc + 1;
    step();
    sys_rst_n = 1'b1;
  endtask

  initial begin
    int b, b2, c;
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; sys_rst_n = 1'b1; wdt_rst_req = 1'b0;
    repeat (3) step();
    check("rst_dom", {28'd0, dom_rst_n}, 32'h0);
    check("rst_busy", {31'd0, seq_busy}, 32'h1);
    check("rst_prdata", prdata, 32'h0);

    // Power-on sequence
    presetn = 1'b1;
    push_seq(0);
    wait_cyc(10);
    apb_read(8'h00, 32'h0000_0004, "status_hold");
    wait_cyc(36);
    apb_read(8'h00, 32'h0000_0305, "status_release");
    wait_cyc(52);
    apb_write(8'h00, 32'hFFFF_FFFF);
    apb_write(8'h0C, 32'hFFFF_FFFF);
    apb_read(8'h00, 32'h0000_0F02, "status_por_run");
    apb_read(8'h04, 32'h0000_0000, "rst_cnt_por");
    apb_read(8'h08, 32'h0000_0001, "ctrl_por");
    apb_read(8'h0C, 32'h0000_0000, "unmapped_rd");

    // Software reset from RUN
    wait_cyc(70);
    sw_pulse(b);
    push_seq(b);
    wait_cyc(b + 50);
    apb_read(8'h00, 32'h0000_0F12, "status_sw");
    apb_read(8'h04, 32'h0000_0001, "rst_cnt_sw");

    // Watchdog held for 10 cycles, starting mid-RELEASE
    c = cyc + 2;
    wait_cyc(c);
    sw_pulse(b);
    push_dom(b, 1'b1, '0, "dom_assert");
    push_dom(b + 35, 1'b1, 4'b0011, "dom_mid_rel");
    wait_cyc(b + 36);
    wdt_rst_req = 1'b1;
    push_dom(b + 37, 1'b1, '0, "wdt_assert");
    push_dom(b + 41, 1'b1, '0, "wdt_hold");
    repeat (10) step();
    wdt_rst_req = 1'b0;
    push_seq(b + 46);
    wait_cyc(b + 46 + 50);
    apb_read(8'h00, 32'h0000_0F22, "status_wdt");
    apb_read(8'h04, 32'h0000_0003, "rst_cnt_wdt");

    // Watchdog masked
    apb_write(8'h08, 32'h0);
    apb_read(8'h08, 32'h0, "ctrl_off");
    wdt_rst_req = 1'b1;
    push_dom(cyc + 1, 1'b0, '1, "wdt_masked");
    push_dom(cyc + 4, 1'b0, '1, "wdt_masked_after");
    step();
    wdt_rst_req = 1'b0;
    repeat (4) step();
    apb_read(8'h04, 32'h0000_0003, "rst_cnt_masked");
    apb_write(8'h08, 32'h1);
    apb_read(8'h08, 32'h1, "ctrl_on");

    // Simultaneous SW and WDT
    sys_rst_n = 1'b0; wdt_rst_req = 1'b1;
    b = cyc + 1;
    push_seq(b);
    step();
    sys_rst_n = 1'b1; wdt_rst_req = 1'b0;
    wait_cyc(b + 50);
    apb_read(8'h00, 32'h0000_0F32, "status_both");
    apb_read(8'h04, 32'h0000_0004, "rst_cnt_both");

    // Clear write coincides with a counted request
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = AW'(8'h04); pwdata = '0;
    step();
    penable = 1'b1; sys_rst_n = 1'b0;
    b = cyc + 1;
    push_seq(b);
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; sys_rst_n = 1'b1;
    wait_cyc(b + 50);
    apb_read(8'h04, 32'h0000_0000, "rst_cnt_clr_wins");
    apb_read(8'h00, 32'h0000_0F12, "status_clr");

    // Saturation
    force dut.rst_cnt_q = 16'hFFFE;
    step();
    release dut.rst_cnt_q;
    step();
    apb_read(8'h04, 32'h0000_FFFE, "rst_cnt_preset");
    sw_pulse(b);
    push_dom(b, 1'b1, '0, "dom_assert");
    push_dom(b + 20, 1'b1, '0, "dom_early_rel");
    apb_read(8'h04, 32'h0000_FFFF, "rst_cnt_max");
    wait_cyc(b + 20);
    sw_pulse(b2);
    push_seq(b2);
    wait_cyc(b2 + 50);
    apb_read(8'h04, 32'h0000_FFFF, "rst_cnt_sat");

    // Asynchronous reset mid-RELEASE
    apb_write(8'h08, 32'h0);
    sw_pulse(b);
    push_dom(b, 1'b1, '0, "dom_assert");
    push_dom(b + 29, 1'b1, 4'b0001, "dom_pre_async");
    wait_cyc(b + 29);
    #3 presetn = 1'b0;
    #1;
    check("async_dom", {28'd0, dom_rst_n}, 32'h0);
    check("async_busy", {31'd0, seq_busy}, 32'h1);
    step();
    step();
    presetn = 1'b1;
    push_seq(0);
    wait_cyc(52);
    apb_read(8'h00, 32'h0000_0F02, "status_por2");
    apb_read(8'h04, 32'h0000_0000, "rst_cnt_por2");
    apb_read(8'h08, 32'h0000_0001, "ctrl_por2");

    step();
    check("sb_empty", dom_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
